// File: rtl/fft_pkg.sv
// Shared constants and the loader state type for the FFT front end.
// Samples are signed Q8.8 at the default width.
package fft_pkg;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_NPTS   = 8;
    localparam int FFT_FRAC_W = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WRITE = 2'd1,
        ST_START = 2'd2,
        ST_BUSY  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream and FFT-side signals of the loader, grouped with modports.
// slave = the loader itself, master = the stream source / FFT side.
interface fft_sample_loader_if
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int NPTS   = FFT_NPTS
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_real;
    logic signed [DATA_W-1:0] s_imag;
    logic                     s_last;
    logic [NPTS*DATA_W-1:0]   frame_real;
    logic [NPTS*DATA_W-1:0]   frame_imag;
    logic                     fft_write;
    logic                     fft_start;
    logic                     fft_ready;
    logic                     frame_err;

    modport slave (
        input  s_valid, s_real, s_imag, s_last, fft_ready,
        output s_ready, frame_real, frame_imag, fft_write, fft_start, frame_err
    );

    modport master (
        output s_valid, s_real, s_imag, s_last, fft_ready,
        input  s_ready, frame_real, frame_imag, fft_write, fft_start, frame_err
    );
endinterface

// File: rtl/fft_sample_bank.sv
// NPTS-entry complex sample register bank: one write port, packed read-out.
// Samples are stored bit-exact; reset clears every slot.
module fft_sample_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int NPTS   = FFT_NPTS,
    parameter int IDX_W  = $clog2(NPTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic signed [DATA_W-1:0] i_real,
    input  logic signed [DATA_W-1:0] i_imag,
    output logic [NPTS*DATA_W-1:0]   o_real,
    output logic [NPTS*DATA_W-1:0]   o_imag
);
    logic signed [DATA_W-1:0] r_real [NPTS];
    logic signed [DATA_W-1:0] r_imag [NPTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NPTS; k++) begin
                r_real[k] <= '0;
                r_imag[k] <= '0;
            end
        end else if (i_we) begin
            r_real[i_idx] <= i_real;
            r_imag[i_idx] <= i_imag;
        end
    end

    always_comb begin
        o_real = '0;
        o_imag = '0;
        for (int k = 0; k < NPTS; k++) begin
            o_real[DATA_W*k +: DATA_W] = r_real[k];
            o_imag[DATA_W*k +: DATA_W] = r_imag[k];
        end
    end
endmodule

// File: rtl/fft_sample_loader.sv
// Collects NPTS complex samples into a frame and hands it to the FFT (write, start, wait).
// Define FFT_LOADER_DBUF_EN for two banks so the next frame fills while the FFT is busy.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int NPTS   = FFT_NPTS
) (
    input logic                clk,
    input logic                rst,
    fft_sample_loader_if.slave bus
);
    localparam int               IDX_W     = $clog2(NPTS);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NPTS - 1);

    loader_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_cnt;
    logic                   r_rdy_en, r_busy_seen, r_err;
    logic                   w_xfer, w_last_slot, w_fill_done, w_busy_exit, w_swap_go;
    logic [NPTS*DATA_W-1:0] w_frame_real, w_frame_imag;

    assign w_xfer      = bus.s_valid && bus.s_ready;
    assign w_last_slot = (r_cnt == LAST_SLOT);
    assign w_fill_done = w_xfer && w_last_slot;
    // fft_ready is only honoured once a full BUSY cycle has elapsed
    assign w_busy_exit = (r_state == ST_BUSY) && r_busy_seen && bus.fft_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_cnt       <= '0;
            r_rdy_en    <= 1'b0;
            r_busy_seen <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rdy_en    <= 1'b1;
            r_busy_seen <= (r_state == ST_BUSY);
            r_err       <= w_xfer && (w_last_slot != bus.s_last);
            if (w_xfer)
                r_cnt <= (w_last_slot || bus.s_last) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FILL:  if (w_fill_done) w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_BUSY;
            ST_BUSY:  if (w_busy_exit) w_state_nxt = w_swap_go ? ST_WRITE : ST_FILL;
            default:  w_state_nxt = ST_FILL;
        endcase
    end

`ifdef FFT_LOADER_DBUF_EN
    logic                   r_act, r_full, w_fill_sel;
    logic [NPTS*DATA_W-1:0] w_b0_real, w_b0_imag, w_b1_real, w_b1_imag;

    // While idle the presented bank is filled; otherwise the hidden one
    assign w_fill_sel = (r_state == ST_FILL) ? r_act : ~r_act;

    fft_sample_bank #(.DATA_W(DATA_W), .NPTS(NPTS)) u_bank0 (
        .clk(clk), .rst(rst), .i_we(w_xfer && !w_fill_sel), .i_idx(r_cnt),
        .i_real(bus.s_real), .i_imag(bus.s_imag), .o_real(w_b0_real), .o_imag(w_b0_imag)
    );
    fft_sample_bank #(.DATA_W(DATA_W), .NPTS(NPTS)) u_bank1 (
        .clk(clk), .rst(rst), .i_we(w_xfer && w_fill_sel), .i_idx(r_cnt),
        .i_real(bus.s_real), .i_imag(bus.s_imag), .o_real(w_b1_real), .o_imag(w_b1_imag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act  <= 1'b0;
            r_full <= 1'b0;
        end else if (w_busy_exit) begin
            r_act  <= ~r_act;
            r_full <= 1'b0;
        end else if (w_fill_done && (r_state != ST_FILL)) begin
            r_full <= 1'b1;
        end
    end

    assign w_frame_real = r_act ? w_b1_real : w_b0_real;
    assign w_frame_imag = r_act ? w_b1_imag : w_b0_imag;
    assign bus.s_ready  = r_rdy_en && ((r_state == ST_FILL) || !r_full);
    assign w_swap_go    = r_full || w_fill_done;
`else
    fft_sample_bank #(.DATA_W(DATA_W), .NPTS(NPTS)) u_bank (
        .clk(clk), .rst(rst), .i_we(w_xfer), .i_idx(r_cnt),
        .i_real(bus.s_real), .i_imag(bus.s_imag), .o_real(w_frame_real), .o_imag(w_frame_imag)
    );

    assign bus.s_ready = r_rdy_en && (r_state == ST_FILL);
    assign w_swap_go   = 1'b0;
`endif

    assign bus.frame_real = w_frame_real;
    assign bus.frame_imag = w_frame_imag;
    assign bus.fft_write  = (r_state == ST_WRITE);
    assign bus.fft_start  = (r_state == ST_START);
    assign bus.frame_err  = r_err;
endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader with a frame scoreboard checked on every fft_write.
module tb_fft_sample_loader;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int NP = 8;
    localparam int FW = DW * NP;

    typedef struct {
        logic [FW-1:0] re;
        logic [FW-1:0] im;
    } frame_t;

`ifdef FFT_LOADER_DBUF_EN
    localparam logic BUSY_RDY = 1'b1;
`else
    localparam logic BUSY_RDY = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     n_tests = 0, n_fail = 0;
    int     n_write = 0, n_start = 0, n_err = 0;
    int     wr_cyc = -1, st_cyc = -1, last_xfer_cyc = -1;
    frame_t exp_q[$];
    frame_t mon_f;

    fft_sample_loader_if #(.DATA_W(DW), .NPTS(NP)) bus ();
    fft_sample_loader #(.DATA_W(DW), .NPTS(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.fft_write === 1'b1) begin
            n_write++;
            wr_cyc = cyc;
            check("frame_pending", FW'(exp_q.size() > 0), FW'(1));
            if (exp_q.size() > 0) begin
                mon_f = exp_q.pop_front();
                check("frame_real", bus.frame_real, mon_f.re);
                check("frame_imag", bus.frame_imag, mon_f.im);
            end
        end
        if (bus.fft_start === 1'b1) begin
            n_start++;
            st_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) n_err++;
    end

    function automatic frame_t mk(input logic [15:0] b_re, input logic [15:0] s_re,
                                  input logic [15:0] b_im, input logic [15:0] s_im);
        frame_t f;
        for (int k = 0; k < NP; k++) begin
            f.re[DW*k +: DW] = b_re + 16'(k) * s_re;
            f.im[DW*k +: DW] = b_im + 16'(k) * s_im;
        end
        return f;
    endfunction

    // Offer one sample and return at posedge+1 after it transfers
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
        logic ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_real  = re;
        bus.s_imag  = im;
        bus.s_last  = last;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
        end
        if (ok) last_xfer_cyc = cyc;
        check("send_accepted", FW'(ok), FW'(1));
    endtask

    task automatic send_frame(input frame_t f, input logic last_on_end, input logic gap);
        for (int k = 0; k < NP; k++) begin
            send(f.re[DW*k +: DW], f.im[DW*k +: DW], (k == NP - 1) && last_on_end);
            if (gap && k < NP - 1) begin
                bus.s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_start(input int s0);
        for (int i = 0; i < 60 && n_start == s0; i++) begin
            @(posedge clk);
            #1;
        end
        check("start_seen", FW'(n_start), FW'(s0 + 1));
    endtask

    // Called in the first BUSY cycle: raise fft_ready for the second one
    task automatic finish_fft();
        @(posedge clk);
        #1;
        bus.fft_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.fft_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f, fb;
        int w0, e0, s0, s1, s_b;
        bus.s_valid = 1'b0; bus.s_real = '0; bus.s_imag = '0;
        bus.s_last  = 1'b0; bus.fft_ready = 1'b0;

        // Reset values
        #3;
        check("rst_s_ready", FW'(bus.s_ready), FW'(0));
        check("rst_fft_write", FW'(bus.fft_write), FW'(0));
        check("rst_fft_start", FW'(bus.fft_start), FW'(0));
        check("rst_frame_err", FW'(bus.frame_err), FW'(0));
        check("rst_frame_real", bus.frame_real, FW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("s_ready_pre_edge", FW'(bus.s_ready), FW'(0));
        @(posedge clk); #1;
        check("s_ready_post_rst", FW'(bus.s_ready), FW'(1));

        // Ramp, s_valid held
        f = mk(16'h0000, 16'h0100, 16'h0000, 16'h0000);
        exp_q.push_back(f);
        s0 = n_start; e0 = n_err;
        send_frame(f, 1'b1, 1'b0);
        wait_start(s0);
        check("ramp_write_lat", FW'(wr_cyc), FW'(last_xfer_cyc));
        check("ramp_start_lat", FW'(st_cyc), FW'(wr_cyc + 1));
        check("ramp_no_err", FW'(n_err), FW'(e0));
        check("ramp_busy_s_ready", FW'(bus.s_ready), FW'(BUSY_RDY));
        finish_fft();
        check("ramp_back_fill", FW'(bus.s_ready), FW'(1));

        // Gapped ramp
        exp_q.push_back(f);
        s0 = n_start;
        send_frame(f, 1'b1, 1'b1);
        wait_start(s0);
        check("gap_write_lat", FW'(wr_cyc), FW'(last_xfer_cyc));
        check("gap_start_lat", FW'(st_cyc), FW'(wr_cyc + 1));
        finish_fft();

        // Early s_last on the 4th sample, then a full ramp
        w0 = n_write; e0 = n_err; s0 = n_start;
        for (int k = 0; k < 4; k++)
            send(16'h1111 * 16'(k + 1), 16'h2222, k == 3);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        f = mk(16'h0000, 16'h0100, 16'h0003, 16'h0010);
        exp_q.push_back(f);
        send_frame(f, 1'b1, 1'b0);
        wait_start(s0);
        check("early_last_err", FW'(n_err), FW'(e0 + 1));
        check("early_last_writes", FW'(n_write), FW'(w0 + 1));
        finish_fft();

        // Reset after 5 samples, then a full ramp
        for (int k = 0; k < 5; k++)
            send(16'h7F00 + 16'(k), 16'h8001, 1'b0);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_s_ready", FW'(bus.s_ready), FW'(0));
        check("midrst_frame_real", bus.frame_real, FW'(0));
        check("midrst_frame_imag", bus.frame_imag, FW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        w0 = n_write; s0 = n_start;
        f = mk(16'h0000, 16'h0100, 16'hFF00, 16'hFFF0);
        exp_q.push_back(f);
        send_frame(f, 1'b1, 1'b0);
        check("midrst_no_early_write", FW'(n_write), FW'(w0));
        wait_start(s0);
        check("midrst_one_write", FW'(n_write), FW'(w0 + 1));
        finish_fft();

        // 8th sample without s_last: frame completes and frame_err pulses
        w0 = n_write; e0 = n_err; s0 = n_start;
        f = mk(16'h8000, 16'h0101, 16'h7FFF, 16'hFFFF);
        exp_q.push_back(f);
        send_frame(f, 1'b0, 1'b0);
        wait_start(s0);
        check("nolast_err", FW'(n_err), FW'(e0 + 1));
        check("nolast_write", FW'(n_write), FW'(w0 + 1));
        finish_fft();

        // fft_ready already high when fft_start fires
        bus.fft_ready = 1'b1;
        s0 = n_start;
        f = mk(16'h0000, 16'h0100, 16'h0000, 16'h0000);
        exp_q.push_back(f);
        send_frame(f, 1'b1, 1'b0);
        wait_start(s0);
        check("hold_busy1_s_ready", FW'(bus.s_ready), FW'(BUSY_RDY));
        @(posedge clk); #1;
        check("hold_busy2_s_ready", FW'(bus.s_ready), FW'(BUSY_RDY));
        @(posedge clk); #1;
        check("hold_exit_s_ready", FW'(bus.s_ready), FW'(1));
        check("hold_single_start", FW'(n_start), FW'(s0 + 1));
        bus.fft_ready = 1'b0;

`ifdef FFT_LOADER_DBUF_EN
        // Back-to-back frames; the second fills while the FFT is busy
        w0 = n_write; s0 = n_start; s_b = 0;
        f  = mk(16'h0000, 16'h0100, 16'h0000, 16'h0000);
        fb = mk(16'h0800, 16'h0100, 16'h0000, 16'h0000);
        exp_q.push_back(f);
        exp_q.push_back(fb);
        send_frame(f, 1'b1, 1'b0);
        fork
            send_frame(fb, 1'b1, 1'b0);
            begin
                wait_start(s0);
                s_b = st_cyc;
                repeat (9) @(posedge clk);
                #1;
                bus.fft_ready = 1'b1;
            end
        join
        check("dbuf_b_in_busy", FW'(last_xfer_cyc <= s_b + 10), FW'(1));
        s1 = n_start;
        @(posedge clk); #1;
        bus.fft_ready = 1'b0;
        wait_start(s1);
        check("dbuf_second_write_cyc", FW'(wr_cyc), FW'(s_b + 11));
        check("dbuf_writes", FW'(n_write), FW'(w0 + 2));
        check("dbuf_slot0", FW'(bus.frame_real[15:0]), FW'(16'h0800));
        finish_fft();
`endif

        check("scoreboard_empty", FW'(exp_q.size()), FW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
